// File: rtl/sram_arbiter_pkg.sv
// Shared types for the SRAM arbiter: FSM states, owner encoding and strobe bundle.
package sram_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_PULSE = 3'd3,
    ST_WR_HOLD  = 3'd4
  } state_e;

  typedef enum logic {
    OWN_VID  = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
    logic dq_oe;
  } sram_ctl_t;

  localparam sram_ctl_t CTL_IDLE = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, dq_oe: 1'b0};

  // Strobe levels for the cycle spent in a given state.
  function automatic sram_ctl_t ctl_for(input state_e st);
    sram_ctl_t ctl;
    ctl = CTL_IDLE;
    unique case (st)
      ST_RD:       ctl = '{ce_n: 1'b0, oe_n: 1'b0, we_n: 1'b1, dq_oe: 1'b0};
      ST_WR_SETUP: ctl = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b1, dq_oe: 1'b1};
      ST_WR_PULSE: ctl = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b0, dq_oe: 1'b1};
      ST_WR_HOLD:  ctl = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b1, dq_oe: 1'b1};
      default:     ctl = CTL_IDLE;
    endcase
    return ctl;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_cycles);
    return (max_cycles < 2) ? 1 : $clog2(max_cycles);
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester handshakes plus SRAM pin bundle seen by the arbiter.
interface sram_arbiter_if #(
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned DATA_W = 16
);
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_ack;
  logic              vid_rvalid;
  logic [DATA_W-1:0] vid_rdata;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ack;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;

  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_dq_o;
  logic              sram_dq_oe;
  logic [DATA_W-1:0] sram_dq_i;
  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              sram_we_n;

  modport slave (
    input  vid_req, vid_addr, host_req, host_we, host_addr, host_wdata, sram_dq_i,
    output vid_ack, vid_rvalid, vid_rdata, host_ack, host_rvalid, host_rdata,
           sram_addr, sram_dq_o, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n
  );

  modport master (
    output vid_req, vid_addr, host_req, host_we, host_addr, host_wdata, sram_dq_i,
    input  vid_ack, vid_rvalid, vid_rdata, host_ack, host_rvalid, host_rdata,
           sram_addr, sram_dq_o, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n
  );
endinterface

// File: rtl/sram_wait_counter.sv
// Loadable down-counter timing the read and write-pulse phases; done when it reaches zero.
module sram_wait_counter #(
  parameter int unsigned CNT_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             done_c_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_c_o = (cnt_q == '0);
endmodule

// File: rtl/sram_arbiter.sv
// Two-requester async SRAM arbiter: video reads win, host gets a starvation-bounded grant.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = 18,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned READ_CYCLES  = 2,
  parameter int unsigned WRITE_CYCLES = 2,
  parameter int unsigned STARVE_LIMIT = 64
) (
  input logic           clk,
  input logic           reset_n,
  sram_arbiter_if.slave bus
);
  localparam int unsigned MAX_CYC = (READ_CYCLES > WRITE_CYCLES) ? READ_CYCLES : WRITE_CYCLES;
  localparam int unsigned CNT_W   = cnt_width(MAX_CYC);
  localparam int unsigned STV_W   = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  sram_ctl_t         ctl_q, ctl_d;
  logic              vid_ack_q, vid_ack_d, host_ack_q, host_ack_d;
  logic              vid_rvalid_q, vid_rvalid_d, host_rvalid_q, host_rvalid_d;
  logic [DATA_W-1:0] vid_rdata_q, vid_rdata_d, host_rdata_q, host_rdata_d;
  logic [STV_W-1:0]  stv_q, stv_d;
  logic              starve_c, grant_vid_c, grant_host_c;
  logic              cnt_load_c, cnt_done_c;
  logic [CNT_W-1:0]  cnt_val_c;

  sram_wait_counter #(.CNT_W(CNT_W)) u_wait (
    .clk        (clk),
    .rst_n      (reset_n),
    .load_i     (cnt_load_c),
    .load_val_i (cnt_val_c),
    .done_c_o   (cnt_done_c)
  );

  // A starving host overrides the video priority only when it is actually asking.
  assign starve_c     = (STARVE_LIMIT != 0) && (stv_q == STV_W'(STARVE_LIMIT));
  assign grant_host_c = (state_q == ST_IDLE) && bus.host_req && (starve_c || !bus.vid_req);
  assign grant_vid_c  = (state_q == ST_IDLE) && bus.vid_req && !grant_host_c;

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    vid_ack_d     = 1'b0;
    host_ack_d    = 1'b0;
    vid_rvalid_d  = 1'b0;
    host_rvalid_d = 1'b0;
    vid_rdata_d   = vid_rdata_q;
    host_rdata_d  = host_rdata_q;
    cnt_load_c    = 1'b0;
    cnt_val_c     = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_vid_c) begin
          state_d    = ST_RD;
          owner_d    = OWN_VID;
          addr_d     = bus.vid_addr;
          vid_ack_d  = 1'b1;
          cnt_load_c = 1'b1;
          cnt_val_c  = CNT_W'(READ_CYCLES - 1);
        end else if (grant_host_c) begin
          owner_d    = OWN_HOST;
          addr_d     = bus.host_addr;
          wdata_d    = bus.host_wdata;
          host_ack_d = 1'b1;
          if (bus.host_we) begin
            state_d = ST_WR_SETUP;
          end else begin
            state_d    = ST_RD;
            cnt_load_c = 1'b1;
            cnt_val_c  = CNT_W'(READ_CYCLES - 1);
          end
        end
      end
      ST_RD: begin
        if (cnt_done_c) begin
          state_d = ST_IDLE;
          if (owner_q == OWN_VID) begin
            vid_rdata_d  = bus.sram_dq_i;
            vid_rvalid_d = 1'b1;
          end else begin
            host_rdata_d  = bus.sram_dq_i;
            host_rvalid_d = 1'b1;
          end
        end
      end
      ST_WR_SETUP: begin
        state_d    = ST_WR_PULSE;
        cnt_load_c = 1'b1;
        cnt_val_c  = CNT_W'(WRITE_CYCLES - 1);
      end
      ST_WR_PULSE: begin
        if (cnt_done_c) begin
          state_d = ST_WR_HOLD;
        end
      end
      ST_WR_HOLD: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    ctl_d = ctl_for(state_d);
  end

  // The ack cycle belongs to the request just granted, so it is not counted as waiting.
  always_comb begin
    stv_d = stv_q;
    if (grant_host_c || host_ack_q) begin
      stv_d = '0;
    end else if (bus.host_req && (stv_q != STV_W'(STARVE_LIMIT))) begin
      stv_d = stv_q + STV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      owner_q       <= OWN_VID;
      addr_q        <= '0;
      wdata_q       <= '0;
      ctl_q         <= CTL_IDLE;
      vid_ack_q     <= 1'b0;
      host_ack_q    <= 1'b0;
      vid_rvalid_q  <= 1'b0;
      host_rvalid_q <= 1'b0;
      vid_rdata_q   <= '0;
      host_rdata_q  <= '0;
      stv_q         <= '0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      ctl_q         <= ctl_d;
      vid_ack_q     <= vid_ack_d;
      host_ack_q    <= host_ack_d;
      vid_rvalid_q  <= vid_rvalid_d;
      host_rvalid_q <= host_rvalid_d;
      vid_rdata_q   <= vid_rdata_d;
      host_rdata_q  <= host_rdata_d;
      stv_q         <= stv_d;
    end
  end

  assign bus.vid_ack     = vid_ack_q;
  assign bus.vid_rvalid  = vid_rvalid_q;
  assign bus.vid_rdata   = vid_rdata_q;
  assign bus.host_ack    = host_ack_q;
  assign bus.host_rvalid = host_rvalid_q;
  assign bus.host_rdata  = host_rdata_q;
  assign bus.sram_addr   = addr_q;
  assign bus.sram_dq_o   = wdata_q;
  assign bus.sram_dq_oe  = ctl_q.dq_oe;
  assign bus.sram_ce_n   = ctl_q.ce_n;
  assign bus.sram_oe_n   = ctl_q.oe_n;
  assign bus.sram_we_n   = ctl_q.we_n;
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM memory model, read-data scoreboard and cycle-exact strobe checks.
module tb_sram_arbiter;
  localparam int unsigned AW = 18;
  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sram_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .READ_CYCLES(2), .WRITE_CYCLES(2), .STARVE_LIMIT(4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int host_rv_cnt = 0;
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [DW-1:0] vid_q[$];
  logic [DW-1:0] host_q[$];
  int vid_rv_cyc[$];
  int vack_k[$];
  int hack_k[$];
  int exp_we[5] = '{1, 0, 0, 1, 1};
  int exp_oe[5] = '{1, 1, 1, 1, 0};
  int exp_vack[4] = '{1, 4, 10, 13};
  int exp_hack[2] = '{7, 16};
  int nb;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp_v);
    end
  endtask

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return DW'(a) ^ 16'hA5C3;
  endfunction

  // Async SRAM model: read data presented mid-cycle, writes captured while we_n is low.
  always @(negedge clk)
    bus.sram_dq_i <= (!bus.sram_ce_n && !bus.sram_oe_n) ? mem_rd(bus.sram_addr) : '0;

  always @(posedge clk) begin
    if (reset_n && !bus.sram_ce_n && !bus.sram_we_n && bus.sram_dq_oe)
      mem[bus.sram_addr] = bus.sram_dq_o;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset_n && bus.vid_rvalid) begin
      vid_rv_cyc.push_back(cyc);
      if (vid_q.size() == 0) chk("vid_rv_unexp", 32'(bus.vid_rvalid), 32'd0);
      else chk("vid_rdata", 32'(bus.vid_rdata), 32'(vid_q.pop_front()));
    end
    if (reset_n && bus.host_rvalid) begin
      host_rv_cnt++;
      if (host_q.size() == 0) chk("host_rv_unexp", 32'(bus.host_rvalid), 32'd0);
      else chk("host_rdata", 32'(bus.host_rdata), 32'(host_q.pop_front()));
    end
  end

  initial begin
    bus.vid_req    = 1'b0;
    bus.vid_addr   = '0;
    bus.host_req   = 1'b0;
    bus.host_we    = 1'b0;
    bus.host_addr  = '0;
    bus.host_wdata = '0;
    mem[18'h00123] = 16'hBEEF;
    repeat (3) @(negedge clk);

    chk("rst_ce_n", 32'(bus.sram_ce_n), 1);
    chk("rst_oe_n", 32'(bus.sram_oe_n), 1);
    chk("rst_we_n", 32'(bus.sram_we_n), 1);
    chk("rst_dq_oe", 32'(bus.sram_dq_oe), 0);
    chk("rst_acks", 32'({bus.vid_ack, bus.host_ack, bus.vid_rvalid, bus.host_rvalid}), 0);
    chk("rst_addr", 32'(bus.sram_addr), 0);
    chk("rst_rdata", 32'({bus.vid_rdata, bus.host_rdata}), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single video read
    bus.vid_addr = 18'h00123;
    bus.vid_req  = 1'b1;
    vid_q.push_back(mem_rd(18'h00123));
    @(negedge clk);
    chk("rd_ack", 32'(bus.vid_ack), 1);
    chk("rd_oe_n_c1", 32'(bus.sram_oe_n), 0);
    chk("rd_ce_n_c1", 32'(bus.sram_ce_n), 0);
    chk("rd_addr", 32'(bus.sram_addr), 32'h123);
    bus.vid_req = 1'b0;
    @(negedge clk);
    chk("rd_ack_pulse", 32'(bus.vid_ack), 0);
    chk("rd_oe_n_c2", 32'(bus.sram_oe_n), 0);
    @(negedge clk);
    chk("rd_rvalid", 32'(bus.vid_rvalid), 1);
    chk("rd_rdata", 32'(bus.vid_rdata), 32'hBEEF);
    chk("rd_oe_n_c3", 32'(bus.sram_oe_n), 1);
    chk("rd_ce_n_c3", 32'(bus.sram_ce_n), 1);
    @(negedge clk);
    chk("rd_rvalid_pulse", 32'(bus.vid_rvalid), 0);

    // Host write; a video request raised and dropped while busy must never be acked
    bus.host_addr  = 18'h3FFFF;
    bus.host_wdata = 16'h5A5A;
    bus.host_we    = 1'b1;
    bus.host_req   = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("wr_ack", 32'(bus.host_ack), 1);
        bus.host_req = 1'b0;
        bus.vid_req  = 1'b1;
      end
      if (k == 1) bus.vid_req = 1'b0;
      chk($sformatf("wr_we_n[%0d]", k), 32'(bus.sram_we_n), 32'(exp_we[k]));
      chk($sformatf("wr_dq_oe[%0d]", k), 32'(bus.sram_dq_oe), 32'(exp_oe[k]));
      chk($sformatf("wr_oe_n[%0d]", k), 32'(bus.sram_oe_n), 1);
      chk($sformatf("wr_no_vack[%0d]", k), 32'(bus.vid_ack), 0);
      if (k < 4) chk($sformatf("wr_dq_o[%0d]", k), 32'(bus.sram_dq_o), 32'h5A5A);
    end
    @(negedge clk);
    chk("wr_dropped_vreq", 32'(bus.vid_ack), 0);
    chk("wr_mem", 32'(mem_rd(18'h3FFFF)), 32'h5A5A);

    // Simultaneous requests with an empty starvation count: video first
    bus.vid_addr  = 18'h00200;
    bus.host_addr = 18'h00300;
    bus.host_we   = 1'b0;
    bus.vid_req   = 1'b1;
    bus.host_req  = 1'b1;
    vid_q.push_back(mem_rd(18'h00200));
    host_q.push_back(mem_rd(18'h00300));
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("both_vack", 32'(bus.vid_ack), 1);
        bus.vid_req = 1'b0;
      end
      if (k < 4) chk($sformatf("both_hack_wait[%0d]", k), 32'(bus.host_ack), 0);
      if (k == 3) chk("both_vrvalid", 32'(bus.vid_rvalid), 1);
      if (k == 4) begin
        chk("both_hack", 32'(bus.host_ack), 1);
        bus.host_req = 1'b0;
      end
      if (k == 6) chk("both_hrvalid", 32'(bus.host_rvalid), 1);
    end

    // Starvation: video held continuously, host forced in after four waiting cycles
    @(negedge clk);
    bus.vid_addr  = 18'h01000;
    bus.host_addr = 18'h02000;
    bus.vid_req   = 1'b1;
    bus.host_req  = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.vid_ack) begin
        vack_k.push_back(k);
        vid_q.push_back(mem_rd(bus.vid_addr));
        bus.vid_addr = bus.vid_addr + 1'b1;
        if (vack_k.size() == 4) bus.vid_req = 1'b0;
      end
      if (bus.host_ack) begin
        hack_k.push_back(k);
        host_q.push_back(mem_rd(bus.host_addr));
        bus.host_req = 1'b0;
      end
      if (k == 10) begin
        bus.host_addr = 18'h02100;
        bus.host_req  = 1'b1;
      end
    end
    chk("stv_vack_cnt", 32'(vack_k.size()), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("stv_vack[%0d]", i), (i < vack_k.size()) ? 32'(vack_k[i]) : 32'hFFFF, 32'(exp_vack[i]));
    chk("stv_hack_cnt", 32'(hack_k.size()), 2);
    for (int i = 0; i < 2; i++)
      chk($sformatf("stv_hack[%0d]", i), (i < hack_k.size()) ? 32'(hack_k[i]) : 32'hFFFF, 32'(exp_hack[i]));

    // Back-to-back video reads of addresses 0..7
    vid_rv_cyc.delete();
    bus.vid_addr = '0;
    bus.vid_req  = 1'b1;
    nb = 0;
    for (int k = 1; k <= 28; k++) begin
      @(negedge clk);
      if (bus.vid_ack && bus.vid_req) begin
        vid_q.push_back(mem_rd(bus.vid_addr));
        bus.vid_addr = bus.vid_addr + 1'b1;
        nb++;
        if (nb == 8) bus.vid_req = 1'b0;
      end
    end
    chk("b2b_rv_cnt", 32'(vid_rv_cyc.size()), 8);
    for (int i = 1; i < 8; i++)
      chk($sformatf("b2b_gap[%0d]", i),
          (i < vid_rv_cyc.size()) ? 32'(vid_rv_cyc[i] - vid_rv_cyc[i-1]) : 32'hFFFF, 3);

    // Reset in the middle of a write pulse drops strobes without a clock edge
    bus.host_addr  = 18'h00050;
    bus.host_wdata = 16'h1234;
    bus.host_we    = 1'b1;
    bus.host_req   = 1'b1;
    for (int k = 0; k < 6 && bus.sram_we_n; k++) @(negedge clk);
    chk("mid_in_pulse", 32'(bus.sram_we_n), 0);
    reset_n      = 1'b0;
    bus.host_req = 1'b0;
    #1;
    chk("mid_we_n", 32'(bus.sram_we_n), 1);
    chk("mid_dq_oe", 32'(bus.sram_dq_oe), 0);
    chk("mid_ce_n", 32'(bus.sram_ce_n), 1);
    chk("mid_oe_n", 32'(bus.sram_oe_n), 1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_acks", 32'({bus.vid_ack, bus.host_ack}), 0);
    chk("post_rst_ce_n", 32'(bus.sram_ce_n), 1);

    chk("vid_q_drained", 32'(vid_q.size()), 0);
    chk("host_q_drained", 32'(host_q.size()), 0);
    chk("host_rv_total", 32'(host_rv_cnt), 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
Arbitrates one external asynchronous SRAM between two requesters: the video pixel-fetch port (read-only, latency-critical) and a host port (read/write, e.g. a frame-buffer writer). It sequences the SRAM control strobes and tristate data enable with configurable wait states. It sits between the vga/dvid pixel path and the SRAM pins, in the `clk` domain.

Parameters:
ADDR_W, 18, SRAM word address width
DATA_W, 16, SRAM data width
READ_CYCLES, 2, clk cycles oe_n held low per read (>=1)
WRITE_CYCLES, 2, clk cycles we_n held low per write (>=1)
STARVE_LIMIT, 64, host pending cycles before forced host grant (0 = never force)

Ports:
clk  in  1  system clock; single clock domain, rising edge
reset_n  in  1  asynchronous, active-low reset
vid_req  in  1  video read request; held until vid_ack
vid_addr  in  ADDR_W  video read address
vid_ack  out  1  one-cycle pulse: video request accepted
vid_rvalid  out  1  one-cycle pulse: vid_rdata valid
vid_rdata  out  DATA_W  video read data
host_req  in  1  host request; held with host_we/addr/wdata until host_ack
host_we  in  1  1 = write, 0 = read
host_addr  in  ADDR_W  host address
host_wdata  in  DATA_W  host write data
host_ack  out  1  one-cycle pulse: host request accepted
host_rvalid  out  1  one-cycle pulse: host_rdata valid (reads only)
host_rdata  out  DATA_W  host read data
sram_addr  out  ADDR_W  SRAM address pins
sram_dq_o  out  DATA_W  SRAM data out (to tristate buffer)
sram_dq_oe  out  1  1 = drive sram_dq_o onto pins
sram_dq_i  in  DATA_W  SRAM data in from pins
sram_ce_n / sram_oe_n / sram_we_n  out  1 each  SRAM strobes, active-low

Behaviour:
- Reset (async, reset_n=0): FSM=IDLE; all *_ack, *_rvalid=0; *_rdata=0; sram_addr=0; sram_dq_o=0; sram_dq_oe=0; ce_n=oe_n=we_n=1; starvation counter=0. Mid-access reset aborts immediately; strobes deassert without waiting for a clock edge.
- All outputs registered. States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD.
- IDLE arbitration at each edge: if starve flag set and host_req, host wins; else vid_req wins over host_req; else stay IDLE. The winner's ack is high for exactly the next cycle; address/data/owner are latched at the grant edge.
- RD: ce_n=0, oe_n=0, we_n=1, dq_oe=0 for READ_CYCLES cycles. sram_dq_i is sampled at the edge ending the last RD cycle into the owner's rdata. The owner's rvalid is high for the following cycle (in IDLE); rdata holds until the next read by that owner.
- Write: WR_SETUP 1 cycle (ce_n=0, we_n=1, dq_oe=1); WR_PULSE WRITE_CYCLES cycles (we_n=0); WR_HOLD 1 cycle (we_n=1, dq_oe=1, data/addr stable); then IDLE. oe_n=1 throughout.
- IDLE always lasts at least 1 cycle between accesses (bus turnaround): read cost READ_CYCLES+1, write WRITE_CYCLES+3.
- Starvation counter: increments each cycle host_req=1 and host not granted, saturating at STARVE_LIMIT; clears on host_ack. Starve flag = (counter==STARVE_LIMIT) && STARVE_LIMIT!=0.
- Requester dropping req before ack: no access occurs. Ack is never asserted to a requester whose req was 0 at the grant edge.
- ce_n=1 in IDLE.

Decomposition:
- Shared package: state encoding constants (IDLE/RD/WR_SETUP/WR_PULSE/WR_HOLD), owner encoding (OWN_VID, OWN_HOST).
- One sub-module is natural: sram_wait_counter (loadable down-counter, terminal flag) reused for RD and WR_PULSE timing. Arbitration plus starvation logic stays in the top.

Test Plan:
- Reset mid-write (assert reset_n=0 during WR_PULSE) -> we_n=1, dq_oe=0, ce_n=1 before next edge; after release, IDLE with all acks 0.
- Single video read, addr 0x00123, model returns 0xBEEF, READ_CYCLES=2 -> vid_ack 1 cycle after the grant edge; oe_n low 2 cycles; vid_rvalid=1 with vid_rdata=0xBEEF on the 3rd cycle after the grant edge.
- Host write addr 0x3FFFF data 0x5A5A, WRITE_CYCLES=2 -> sequence setup(1)/pulse(2)/hold(1); dq_oe high for 4 cycles; model memory[0x3FFFF]=0x5A5A; host_rvalid never asserted.
- vid_req and host_req both asserted in IDLE, counter 0 -> vid_ack first; host_ack after the video read plus 1 IDLE cycle.
- vid_req held continuously, host_req held, STARVE_LIMIT=4 -> host granted at the first IDLE after the counter reaches 4; counter returns to 0 after host_ack.
- Back-to-back video reads of addrs 0..7 -> 8 rvalid pulses spaced exactly 3 cycles apart, data in order.
